// File: rtl/jericalla_pkg.sv
// Shared constants, instruction field slices and shadow-slot type for the jericalla issue stage.
package jericalla_pkg;

    localparam int INSTR_W = 18;
    localparam int REG_AW  = 5;
    localparam int OP_W    = 3;
    localparam int OP_MSB  = 17;
    localparam int OP_LSB  = 15;
    localparam int WA_MSB  = 14;
    localparam int WA_LSB  = 10;
    localparam int RA1_MSB = 9;
    localparam int RA1_LSB = 5;
    localparam int RA2_MSB = 4;
    localparam int RA2_LSB = 0;

    localparam logic [INSTR_W-1:0] NOP_ENC = 18'h00000;

    typedef struct packed {
        logic              wb;
        logic [REG_AW-1:0] wa;
    } shadow_t;

    // True when the opcode's bit is set in the write-back mask.
    function automatic logic writes_back(input logic [7:0] mask, input logic [OP_W-1:0] op);
        return mask[op];
    endfunction

endpackage

// File: rtl/jericalla_issue_fifo.sv
// Generic synchronous FIFO; pointers carry an extra wrap bit so full and empty differ only in the MSB.
module jericalla_issue_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // Qualify requests against the current state; a full FIFO refuses pushes even alongside a pop.
    always_comb begin
        push_ok_s = push && !full;
        pop_ok_s  = pop && !empty;
        wr_ptr_d  = push_ok_s ? (wr_ptr_q + {{AW{1'b0}}, 1'b1}) : wr_ptr_q;
        rd_ptr_d  = pop_ok_s  ? (rd_ptr_q + {{AW{1'b0}}, 1'b1}) : rd_ptr_q;
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are meaningless once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/jericalla_issue.sv
// Issue stage: FIFO-buffered instruction source with RAW-hazard bubble insertion.
// Optional statistics counters are built when JERICALLA_ISSUE_STATS_EN is defined.
module jericalla_issue
    import jericalla_pkg::*;
#(
    parameter int                 DEPTH        = 4,
    parameter int                 HAZARD_DEPTH = 2,
    parameter logic [7:0]         WB_OP_MASK   = 8'b1111_1110,
    parameter logic [INSTR_W-1:0] NOP_INSTR    = NOP_ENC
) (
    input  logic               clk_jericalla,
    input  logic               rst_n_jericalla,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               in_ready,
    input  logic               halt,
    output logic [INSTR_W-1:0] instruccion,
    output logic               issue_valid,
    output logic               fifo_empty
`ifdef JERICALLA_ISSUE_STATS_EN
    ,
    output logic [31:0]        stat_issued,
    output logic [31:0]        stat_bubbles
`endif
);

    logic [INSTR_W-1:0] head_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               hazard_s;
    logic               issue_ok_s;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    shadow_t            sh_q [2];
    shadow_t            sh_d [2];

    jericalla_issue_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_jericalla),
        .rst_n (rst_n_jericalla),
        .push  (in_valid),
        .pop   (issue_ok_s),
        .din   (in_instr),
        .head  (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign in_ready    = rst_n_jericalla && !fifo_full_s;
    assign fifo_empty  = fifo_empty_s;
    assign instruccion = instr_q;
    assign issue_valid = valid_q;

    // Hazard check of the FIFO head against in-flight writers, then the issue decision.
    always_comb begin
        hazard_s = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if ((k < HAZARD_DEPTH) && sh_q[k].wb &&
                ((sh_q[k].wa == head_s[RA1_MSB:RA1_LSB]) ||
                 (sh_q[k].wa == head_s[RA2_MSB:RA2_LSB]))) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
        issue_ok_s = !halt && !fifo_empty_s && !hazard_s;
        if (issue_ok_s) begin
            instr_d = head_s;
            valid_d = 1'b1;
        end else begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end
        // Bubbles enter the shadow chain with wb cleared so stalls drain on their own.
        sh_d[0].wb = writes_back(WB_OP_MASK, instr_d[OP_MSB:OP_LSB]) && valid_d;
        sh_d[0].wa = instr_d[WA_MSB:WA_LSB];
        sh_d[1]    = sh_q[0];
    end

    // Issue register and shadow chain.
    always_ff @(posedge clk_jericalla or negedge rst_n_jericalla) begin
        if (!rst_n_jericalla) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            sh_q[0] <= '0;
            sh_q[1] <= '0;
        end else begin
            instr_q <= instr_d;
            valid_q <= valid_d;
            sh_q[0] <= sh_d[0];
            sh_q[1] <= sh_d[1];
        end
    end

`ifdef JERICALLA_ISSUE_STATS_EN
    logic [31:0] stat_issued_q, stat_issued_d;
    logic [31:0] stat_bubbles_q, stat_bubbles_d;

    assign stat_issued  = stat_issued_q;
    assign stat_bubbles = stat_bubbles_q;

    // Bubbles are counted only when a hazard alone blocked a ready head.
    always_comb begin
        stat_issued_d  = stat_issued_q + (issue_ok_s ? 32'd1 : 32'd0);
        stat_bubbles_d = stat_bubbles_q +
                         ((!halt && !fifo_empty_s && hazard_s) ? 32'd1 : 32'd0);
    end

    // Statistics counters, wrapping modulo 2^32.
    always_ff @(posedge clk_jericalla or negedge rst_n_jericalla) begin
        if (!rst_n_jericalla) begin
            stat_issued_q  <= 32'd0;
            stat_bubbles_q <= 32'd0;
        end else begin
            stat_issued_q  <= stat_issued_d;
            stat_bubbles_q <= stat_bubbles_d;
        end
    end
`endif

endmodule
